// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache FSM states, default frame layout
// and a word-alignment helper.
package cpu_types_pkg;

  localparam int unsigned ICACHE_IDX_W = 4;
  localparam int unsigned ICACHE_TAG_W = 26;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [31:0]             data;
  } icache_frame_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side datapath signals plus the instruction half of the memory bus.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_ctrl.sv
// Miss-handling FSM: latches the missing word address, drives the memory
// read and emits a one-cycle fill strobe when memory data arrives.
module icache_ctrl
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req,
  input  logic        lookup_hit,
  input  logic [31:0] req_addr,
  input  logic        iwait,
  output logic        iREN,
  output logic [31:0] iaddr,
  output logic        fill,
  output logic        idle,
  output logic [29:0] fill_word
);

  icache_state_t state, next_state;
  logic [31:0]   miss_addr;
  logic          capture;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= '0;
    end else begin
      state <= next_state;
      if (capture) miss_addr <= word_align(req_addr);
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (req && !lookup_hit) next_state = FETCH;
      FETCH:   if (!iwait) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Redirects during FETCH are ignored: the fill always targets miss_addr.
  always_comb begin
    iREN    = 1'b0;
    fill    = 1'b0;
    capture = 1'b0;
    idle    = 1'b0;
    unique case (state)
      IDLE: begin
        idle    = 1'b1;
        capture = req && !lookup_hit;
      end
      FETCH: begin
        iREN = 1'b1;
        fill = !iwait;
      end
      default: ;
    endcase
  end

  assign iaddr     = miss_addr;
  assign fill_word = miss_addr[31:2];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-block instruction cache. Define ICACHE_STATS_EN
// to add the hit_cnt / miss_cnt statistics outputs.
module icache
  import cpu_types_pkg::*;
#(
  parameter int unsigned NSETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  icache_if.slave     bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(NSETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } frame_t;

  frame_t           frames [NSETS];
  frame_t           req_frame;
  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic [29:0]      fill_word;
  logic             lookup_hit, ihit, fill, idle;

  assign req_idx   = bus.imemaddr[IDX_W+1:2];
  assign req_tag   = bus.imemaddr[31:IDX_W+2];
  assign fill_idx  = fill_word[IDX_W-1:0];
  assign fill_tag  = fill_word[29:IDX_W];
  assign req_frame = frames[req_idx];

  assign lookup_hit = bus.imemREN && req_frame.valid && (req_frame.tag == req_tag);
  // A lookup that matches while a fill is outstanding is still reported as a miss.
  assign ihit         = lookup_hit && idle;
  assign bus.ihit     = ihit;
  assign bus.imemload = ihit ? req_frame.data : '0;

  icache_ctrl u_ctrl (
    .CLK        (CLK),
    .nRST       (nRST),
    .req        (bus.imemREN),
    .lookup_hit (lookup_hit),
    .req_addr   (bus.imemaddr),
    .iwait      (bus.iwait),
    .iREN       (bus.iREN),
    .iaddr      (bus.iaddr),
    .fill       (fill),
    .idle       (idle),
    .fill_word  (fill_word)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < NSETS; i++) frames[i] <= '0;
    end else if (fill) begin
      frames[fill_idx] <= '{valid: 1'b1, tag: fill_tag, data: bus.iload};
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (ihit) hit_cnt  <= hit_cnt + 32'd1;
      if (fill) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed-vector bench for icache (NSETS=16): cold miss, hits, conflict
// eviction, redirect during fill, reset during fill and optional counters.
module tb_icache;

  logic clk;
  logic nrst;
  int   total;
  int   bad;

  icache_if bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  icache #(.NSETS(16)) dut (
    .CLK      (clk),
    .nRST     (nrst),
    .bus      (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ren;
    logic [31:0] addr;
    logic        iwait;
    logic [31:0] iload;
    logic        ihit;
    logic [31:0] load;
    logic        iren;
    logic [31:0] iaddr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(string n, logic r, logic [31:0] a, logic w, logic [31:0] ld,
                              logic eh, logic [31:0] el, logic er, logic [31:0] ea);
    vec_t v;
    v.name = n; v.ren = r; v.addr = a; v.iwait = w; v.iload = ld;
    v.ihit = eh; v.load = el; v.iren = er; v.iaddr = ea;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive just after the rising edge, check at the falling edge.
  // iaddr is only meaningful while iREN is asserted.
  task automatic cyc(input string nm, input logic r, input logic [31:0] a, input logic w,
                     input logic [31:0] ld, input logic eh, input logic [31:0] el,
                     input logic er, input logic [31:0] ea);
    @(posedge clk);
    #1;
    bus.imemREN  = r;
    bus.imemaddr = a;
    bus.iwait    = w;
    bus.iload    = ld;
    @(negedge clk);
    chk({nm, ".ihit"}, {31'd0, bus.ihit}, {31'd0, eh});
    chk({nm, ".imemload"}, bus.imemload, el);
    chk({nm, ".iREN"}, {31'd0, bus.iREN}, {31'd0, er});
    if (er) chk({nm, ".iaddr"}, bus.iaddr, ea);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    nrst  = 1'b0;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h40;
    bus.iwait    = 1'b0;
    bus.iload    = 32'hDEADBEEF;

    // name, ren, addr, iwait, iload  ->  ihit, imemload, iREN, iaddr
    vt.push_back(mk("idle",      0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0));
    vt.push_back(mk("cold_miss", 1, 32'h40,       1, 32'h0,        0, 32'h0,        0, 32'h0));
    vt.push_back(mk("cold_w1",   1, 32'h40,       1, 32'h0,        0, 32'h0,        1, 32'h40));
    vt.push_back(mk("cold_w2",   1, 32'h40,       1, 32'h0,        0, 32'h0,        1, 32'h40));
    vt.push_back(mk("cold_w3",   1, 32'h40,       1, 32'h0,        0, 32'h0,        1, 32'h40));
    vt.push_back(mk("cold_fill", 1, 32'h40,       0, 32'h8C220004, 0, 32'h0,        1, 32'h40));
    vt.push_back(mk("hit40",     1, 32'h40,       0, 32'h0,        1, 32'h8C220004, 0, 32'h0));
    vt.push_back(mk("hit41",     1, 32'h41,       0, 32'h0,        1, 32'h8C220004, 0, 32'h0));
    vt.push_back(mk("no_req",    0, 32'h40,       0, 32'h0,        0, 32'h0,        0, 32'h0));
    vt.push_back(mk("miss0",     1, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0));
    vt.push_back(mk("fill0",     1, 32'h0,        0, 32'hAAAA0000, 0, 32'h0,        1, 32'h0));
    vt.push_back(mk("hit0",      1, 32'h0,        0, 32'h0,        1, 32'hAAAA0000, 0, 32'h0));
    vt.push_back(mk("evict40",   1, 32'h40,       0, 32'h0,        0, 32'h0,        0, 32'h0));
    vt.push_back(mk("fill40",    1, 32'h40,       0, 32'h8C220004, 0, 32'h0,        1, 32'h40));
    vt.push_back(mk("hit40b",    1, 32'h40,       0, 32'h0,        1, 32'h8C220004, 0, 32'h0));
    vt.push_back(mk("miss0b",    1, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0));
    vt.push_back(mk("refetch0",  1, 32'h0,        0, 32'hAAAA0000, 0, 32'h0,        1, 32'h0));
    vt.push_back(mk("hit0b",     1, 32'h0,        0, 32'h0,        1, 32'hAAAA0000, 0, 32'h0));
    vt.push_back(mk("miss_top",  1, 32'hFFFFFFFC, 0, 32'h0,        0, 32'h0,        0, 32'h0));
    vt.push_back(mk("fill_top",  1, 32'hFFFFFFFC, 0, 32'h12345678, 0, 32'h0,        1, 32'hFFFFFFFC));
    vt.push_back(mk("hit_top",   1, 32'hFFFFFFFF, 0, 32'h0,        1, 32'h12345678, 0, 32'h0));
    vt.push_back(mk("tag_msb",   1, 32'h7FFFFFFC, 0, 32'h0,        0, 32'h0,        0, 32'h0));
    vt.push_back(mk("fill_msb",  1, 32'h7FFFFFFC, 0, 32'h0BADF00D, 0, 32'h0,        1, 32'h7FFFFFFC));
    vt.push_back(mk("hit_msb",   1, 32'h7FFFFFFC, 0, 32'h0,        1, 32'h0BADF00D, 0, 32'h0));
    vt.push_back(mk("top_gone",  1, 32'hFFFFFFFC, 1, 32'h0,        0, 32'h0,        0, 32'h0));
    vt.push_back(mk("top_fill2", 1, 32'hFFFFFFFC, 0, 32'h12345678, 0, 32'h0,        1, 32'hFFFFFFFC));
    vt.push_back(mk("idle2",     0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0));

    // Reset values while nRST is held low.
    @(negedge clk);
    chk("rst.ihit", {31'd0, bus.ihit}, 32'd0);
    chk("rst.imemload", bus.imemload, 32'h0);
    chk("rst.iREN", {31'd0, bus.iREN}, 32'd0);
    chk("rst.iaddr", bus.iaddr, 32'h0);
`ifdef ICACHE_STATS_EN
    chk("rst.hit_cnt", hit_cnt, 32'h0);
    chk("rst.miss_cnt", miss_cnt, 32'h0);
`endif
    bus.imemREN = 1'b0;
    @(posedge clk);
    #1 nrst = 1'b1;

    foreach (vt[i])
      cyc(vt[i].name, vt[i].ren, vt[i].addr, vt[i].iwait, vt[i].iload,
          vt[i].ihit, vt[i].load, vt[i].iren, vt[i].iaddr);

    // Redirect to 0x200 during the 0x100 fill; both share frame 0 with 16 sets.
    cyc("rd_miss",   1, 32'h100, 1, 32'h0,        0, 32'h0,        0, 32'h0);
    cyc("rd_redir",  1, 32'h200, 1, 32'h0,        0, 32'h0,        1, 32'h100);
    cyc("rd_fill",   1, 32'h200, 0, 32'h11110100, 0, 32'h0,        1, 32'h100);
    cyc("rd_miss2",  1, 32'h200, 1, 32'h0,        0, 32'h0,        0, 32'h0);
    cyc("rd_nohit",  1, 32'h100, 1, 32'h0,        0, 32'h0,        1, 32'h200);
    cyc("rd_fill2",  1, 32'h100, 0, 32'h22220200, 0, 32'h0,        1, 32'h200);
    cyc("rd_hit200", 1, 32'h200, 0, 32'h0,        1, 32'h22220200, 0, 32'h0);
    cyc("rd_miss3",  1, 32'h100, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    cyc("rd_fill3",  1, 32'h100, 0, 32'h11110100, 0, 32'h0,        1, 32'h100);
    cyc("rd_hit100", 1, 32'h100, 0, 32'h0,        1, 32'h11110100, 0, 32'h0);

    // Reset asserted in the middle of a fill.
    cyc("rf_miss",   1, 32'h300, 1, 32'h0,        0, 32'h0,        0, 32'h0);
    cyc("rf_wait",   1, 32'h300, 1, 32'h0,        0, 32'h0,        1, 32'h300);
    @(posedge clk);
    #1 nrst = 1'b0;
    #1;
    chk("rf.iREN", {31'd0, bus.iREN}, 32'd0);
    chk("rf.iaddr", bus.iaddr, 32'h0);
    bus.imemaddr = 32'h100;
    #1;
    chk("rf.ihit100", {31'd0, bus.ihit}, 32'd0);
    chk("rf.imemload", bus.imemload, 32'h0);
    bus.imemREN = 1'b0;
    #1 nrst = 1'b1;

    cyc("pr_miss",   1, 32'h100, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    cyc("pr_fill",   1, 32'h100, 0, 32'hCAFE0100, 0, 32'h0,        1, 32'h100);
    for (int k = 0; k < 6; k++)
      cyc("pr_hit",  1, 32'h100, 0, 32'h0,        1, 32'hCAFE0100, 0, 32'h0);
    cyc("pr_idle",   0, 32'h100, 0, 32'h0,        0, 32'h0,        0, 32'h0);
`ifdef ICACHE_STATS_EN
    chk("stats.miss_cnt", miss_cnt, 32'd1);
    chk("stats.hit_cnt", hit_cnt, 32'd6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
